data_memory_param: RTL and testbench



---
 rtl/data_memory_param.sv | 156 +++++++++++++++
 tb/tb_data_memory_param.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
// Parametrised single-port data memory with byte enables, hardware clear sweep and out-of-range flagging.
// Latency: read response READ_LAT (1 or 2) cycles after acceptance; writes land at the acceptance edge.
// Backpressure: req_ready drops during a clear sweep and when clr_start is raised; responses cannot be stalled.
module data_memory_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                clr_start,
    output logic                busy,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                err_oob
);

    localparam int NB = DATA_W / 8;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    // Last word of the sweep and the first illegal address, widened by one bit so DEPTH == 2**ADDR_W fits.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              addr_oob;
    logic [DATA_W-1:0] rd_word;

    // Data presented to the final response register, either straight from the array or one stage later.
    logic              out_vld;
    logic              out_oob;
    logic [DATA_W-1:0] out_dat;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              err_oob_q;

    assign req_ready = (state_q == S_READY) && !clr_start;
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_write;
    assign wr_acc    = accept && req_write;
    assign addr_oob  = ({1'b0, req_addr} >= DEPTH_V);
    // Out-of-range reads must never index the array; they return zero.
    assign rd_word   = addr_oob ? '0 : mem_q[req_addr];

    // Clear/ready sequencing: sweep every word once, then serve requests until a new clear is requested.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == S_CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = S_READY;
                clr_addr_d = '0;
            end
        end else if (clr_start) begin
            state_d    = S_CLEAR;
            clr_addr_d = '0;
        end
    end

    // FSM state, sweep pointer and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= (state_d == S_CLEAR);
        end
    end

    // Array update: the sweep owns the write port while clearing, otherwise accepted in-range writes per byte.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_acc && !addr_oob) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s1_vld_q;
            logic              s1_oob_q;
            logic [DATA_W-1:0] s1_dat_q;

            // Extra read stage; the word is captured at acceptance so a later clear cannot alter it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_vld_q <= 1'b0;
                    s1_oob_q <= 1'b0;
                    s1_dat_q <= '0;
                end else begin
                    s1_vld_q <= rd_acc;
                    s1_oob_q <= rd_acc && addr_oob;
                    if (rd_acc) begin
                        s1_dat_q <= rd_word;
                    end
                end
            end

            assign out_vld = s1_vld_q;
            assign out_oob = s1_oob_q;
            assign out_dat = s1_dat_q;
        end else begin : g_lat1
            assign out_vld = rd_acc;
            assign out_oob = rd_acc && addr_oob;
            assign out_dat = rd_word;
        end
    endgenerate

    // Response stage: data holds between responses; err_oob merges read-side and write-side range errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_oob_q   <= 1'b0;
        end else begin
            rsp_valid_q <= out_vld;
            if (out_vld) begin
                rsp_rdata_q <= out_dat;
            end
            err_oob_q <= (out_vld && out_oob) || (wr_acc && addr_oob);
        end
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: two instances (256 words/latency 1 and 200 words/latency 2) share one stimulus.
// Latency: expectations are scheduled per cycle from an array model and compared every cycle.
// Backpressure: acceptance is predicted from the model's clear state and clr_start.
module tb_data_memory_param;

    localparam int NC = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        clr_start;

    logic        rdy  [2];
    logic        bsy  [2];
    logic        vld  [2];
    logic        oob  [2];
    logic [31:0] rdat [2];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: word arrays, remaining clear cycles, last response data, per-cycle expectations.
    logic [31:0] mdl [2][256];
    int          clr_left [2];
    logic [31:0] last [2];
    bit          ev [2][NC];
    bit          eo [2][NC];
    bit          ee [2][NC];
    logic [31:0] ed [2][NC];

    always #5 clk = ~clk;

    data_memory_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .READ_LAT(1)) u_d0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clr_start(clr_start), .busy(bsy[0]), .rsp_valid(vld[0]), .rsp_rdata(rdat[0]),
        .err_oob(oob[0])
    );

    data_memory_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .READ_LAT(2)) u_d1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clr_start(clr_start), .busy(bsy[1]), .rsp_valid(vld[1]), .rsp_rdata(rdat[1]),
        .err_oob(oob[1])
    );

    function automatic int dep(int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: check ready before the edge, advance the model at the edge, check outputs at the falling edge.
    task automatic tick();
        bit acc [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d ready", k), rdy[k], (clr_left[k] == 0) && !clr_start);
            acc[k] = req_valid && (clr_left[k] == 0) && !clr_start;
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (clr_left[k] > 0) begin
                clr_left[k]--;
                if (clr_left[k] == 0) begin
                    for (int a = 0; a < dep(k); a++) mdl[k][a] = '0;
                end
            end else if (clr_start) begin
                clr_left[k] = dep(k);
            end else if (acc[k]) begin
                int a;
                bit bad;
                a   = int'(req_addr);
                bad = (a >= dep(k));
                if (req_write) begin
                    if (bad) ee[k][cyc % NC] = 1'b1;
                    else begin
                        for (int b = 0; b < 4; b++) begin
                            if (req_be[b]) mdl[k][a][8*b +: 8] = req_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    int d;
                    d = (cyc + lat(k) - 1) % NC;
                    ev[k][d] = 1'b1;
                    eo[k][d] = bad;
                    ed[k][d] = bad ? 32'h0 : mdl[k][a];
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int i;
            bit v;
            i = cyc % NC;
            v = ev[k][i];
            if (v) last[k] = ed[k][i];
            chk($sformatf("d%0d rsp_valid", k), vld[k], v);
            chk($sformatf("d%0d rsp_rdata", k), rdat[k], last[k]);
            chk($sformatf("d%0d err_oob", k), oob[k], ee[k][i] | (v & eo[k][i]));
            chk($sformatf("d%0d busy", k), bsy[k], clr_left[k] > 0);
            ev[k][i] = 1'b0;
            eo[k][i] = 1'b0;
            ee[k][i] = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s d%0d busy", tag, k), bsy[k], 1);
            chk($sformatf("%s d%0d ready", tag, k), rdy[k], 0);
            chk($sformatf("%s d%0d rsp_valid", tag, k), vld[k], 0);
            chk($sformatf("%s d%0d rsp_rdata", tag, k), rdat[k], 0);
            chk($sformatf("%s d%0d err_oob", tag, k), oob[k], 0);
        end
    endtask

    // Asserted away from a clock edge so the asynchronous path is what gets observed.
    task automatic apply_reset(int hold);
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_now");
        repeat (hold) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            clr_left[k] = dep(k);
            last[k]     = '0;
            for (int i = 0; i < NC; i++) begin
                ev[k][i] = 1'b0;
                eo[k][i] = 1'b0;
                ee[k][i] = 1'b0;
            end
        end
    endtask

    // Counts cycles from now until each instance reports not busy, bounded.
    task automatic wait_clear(string tag);
        int n0;
        int n1;
        n0 = 0;
        n1 = 0;
        for (int i = 1; i <= 400 && (n0 == 0 || n1 == 0); i++) begin
            tick();
            if (!bsy[0] && n0 == 0) n0 = i;
            if (!bsy[1] && n1 == 0) n1 = i;
        end
        chk({tag, " d0 sweep_len"}, n0, 256);
        chk({tag, " d1 sweep_len"}, n1, 200);
    endtask

    task automatic op(bit wr, int addr, logic [31:0] d, logic [3:0] be);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr[7:0];
        req_wdata = d;
        req_be    = be;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        clr_start = 1'b0;
        #2;
        apply_reset(3);
        wait_clear("boot");

        // Freshly cleared word reads back zero.
        op(0, 'h10, 0, 0);
        idle(3);

        // Full write then a partial byte write merges into the same word.
        op(1, 5, 32'hDEADBEEF, 4'b1111);
        op(1, 5, 32'h000000AA, 4'b0001);
        op(0, 5, 0, 0);
        idle(3);
        chk("merge d0", rdat[0], 32'hDEADBEAA);
        chk("merge d1", rdat[1], 32'hDEADBEAA);

        // Back-to-back reads after writes, including write-then-read on consecutive cycles.
        op(1, 1, 32'h11, 4'hF);
        op(1, 2, 32'h22, 4'hF);
        op(1, 3, 32'h33, 4'hF);
        op(0, 1, 0, 0);
        op(0, 2, 0, 0);
        op(0, 3, 0, 0);
        op(1, 4, 32'hCAFEF00D, 4'b1010);
        op(0, 4, 0, 0);
        op(1, 6, 32'h12345678, 4'b0000);
        op(0, 6, 0, 0);
        idle(3);

        // Out-of-range for the 200-word instance, in range for the 256-word one.
        op(1, 10, 32'h0000_0A0A, 4'hF);
        op(1, 210, 32'hBADC0FFE, 4'hF);
        idle(1);
        op(0, 210, 0, 0);
        op(0, 10, 0, 0);
        op(0, 255, 0, 0);
        op(0, 199, 0, 0);
        idle(3);

        // clr_start alongside a request blocks it and starts a sweep; the read in flight keeps old data.
        op(1, 7, 32'h55, 4'hF);
        op(1, 9, 32'h99, 4'hF);
        op(0, 9, 0, 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'd7;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        req_valid = 1'b0;
        wait_clear("clr");
        op(0, 7, 0, 0);
        idle(3);
        chk("clr d0 addr7", rdat[0], 32'h0);
        chk("clr d1 addr7", rdat[1], 32'h0);

        // Reset in the middle of a sweep restarts it from scratch, dropping any in-flight read.
        op(1, 8, 32'h0808_0808, 4'hF);
        op(0, 8, 0, 0);
        apply_reset(2);
        idle(100);
        apply_reset(2);
        wait_clear("rst_mid");

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 1500; n++) begin
            clr_start = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 9) < 7);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            tick();
        end
        clr_start = 1'b0;
        req_valid = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
